// File: rtl/cci_mpf_shim_edge_pkg.sv
// Shared types for the MPF edge shims (AFU and FIU sides).
// CCI flit structs, heap index/beat types and FIFO threshold.
package cci_mpf_shim_edge_pkg;

  localparam int CCI_TX_ALMOST_FULL_THRESHOLD = 8;
  localparam int MPF_N_WRITE_HEAP_ENTRIES = 128;
  localparam int CCI_CLADDR_W = 42;

  typedef logic [$clog2(MPF_N_WRITE_HEAP_ENTRIES)-1:0] t_write_heap_idx;
  typedef logic [1:0] t_write_heap_beat;
  typedef logic [511:0] t_cci_cl;
  typedef logic [CCI_CLADDR_W-1:0] t_cci_claddr;

  typedef enum logic [1:0] {
    C1_WRITE = 2'd0,
    C1_FENCE = 2'd1,
    C1_INTR  = 2'd2
  } t_c1_req;

  typedef enum logic {
    ST_IDLE,
    ST_BEAT
  } t_edge_state;

  typedef struct packed {
    logic             valid;
    t_c1_req          req;
    logic             sop;
    t_write_heap_beat cl_len;
    t_cci_claddr      addr;
    t_cci_cl          data;
  } t_c1_tx;

  typedef struct packed {
    logic        valid;
    t_cci_claddr addr;
    logic [15:0] mdata;
  } t_c0_tx;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } t_c2_tx;

  typedef struct packed {
    logic        valid;
    logic [15:0] mdata;
    t_cci_cl     data;
  } t_c0_rx;

  typedef struct packed {
    logic        valid;
    logic [15:0] mdata;
  } t_c1_rx;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             last;
    t_write_heap_idx  idx;
    t_write_heap_beat beat;
    t_c1_tx           hdr;
  } t_c1_beat;

  function automatic t_cci_claddr beat_addr(
    input t_cci_claddr a,
    input t_write_heap_beat b
  );
    return a | t_cci_claddr'(b);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_edge_fiu_if.sv
// CCI-P style channel bundle and the AFU/FIU edge heap link.
// Modports name the side the owning module faces.
interface cci_mpf_if;
  import cci_mpf_shim_edge_pkg::*;

  logic   reset;
  t_c0_tx c0Tx;
  t_c1_tx c1Tx;
  t_c2_tx c2Tx;
  logic   c0TxAlmFull;
  logic   c1TxAlmFull;
  t_c0_rx c0Rx;
  t_c1_rx c1Rx;

  modport to_fiu (
    input  reset, c0TxAlmFull, c1TxAlmFull,
    input  c0Rx, c1Rx,
    output c0Tx, c1Tx, c2Tx
  );

  modport to_afu (
    input  c0Tx, c1Tx, c2Tx,
    output reset, c0TxAlmFull, c1TxAlmFull,
    output c0Rx, c1Rx
  );
endinterface

interface cci_mpf_shim_edge_if;
  import cci_mpf_shim_edge_pkg::*;

  logic             wen;
  t_write_heap_idx  widx;
  t_write_heap_beat wclnum;
  t_cci_cl          wdata;
  logic             free;
  t_write_heap_idx  freeidx;

  modport edge_fiu (
    input  wen, widx, wclnum, wdata,
    output free, freeidx
  );

  modport edge_afu (
    output wen, widx, wclnum, wdata,
    input  free, freeidx
  );
endinterface

// File: rtl/cci_mpf_shim_edge_fiu_wr_heap.sv
// Write-data heap: simple dual-port RAM, one line per beat.
// Registered read; contents are never reset.
module cci_mpf_shim_edge_fiu_wr_heap
  import cci_mpf_shim_edge_pkg::*;
#(
  parameter int N_ENTRIES = 128,
  localparam int AW = $clog2(N_ENTRIES) + 2
) (
  input  logic          clk_i,
  input  logic          wen_i,
  input  logic [AW-1:0] waddr_i,
  input  t_cci_cl       wdata_i,
  input  logic [AW-1:0] raddr_i,
  output t_cci_cl       rdata_o
);

  t_cci_cl mem [N_ENTRIES*4];
  t_cci_cl rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk_i) begin
    if (wen_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cci_mpf_shim_edge_fiu.sv
// FIU-side MPF edge: queues c1 control flits, expands writes to beats.
// Define CCI_MPF_SHIM_EDGE_FIU_HEAP_CHECK_EN to track heap slot validity.
module cci_mpf_shim_edge_fiu
  import cci_mpf_shim_edge_pkg::*;
#(
  parameter int N_WRITE_HEAP_ENTRIES = 128,
  parameter int C1_CTRL_FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cci_mpf_if.to_fiu              fiu,
  cci_mpf_if.to_afu              afu,
  cci_mpf_shim_edge_if.edge_fiu  afu_edge
);

  localparam int IDX_W = $clog2(N_WRITE_HEAP_ENTRIES);
  localparam int HEAP_AW = IDX_W + 2;
  localparam int PTR_W = $clog2(C1_CTRL_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ALM_LVL =
    C1_CTRL_FIFO_DEPTH - CCI_TX_ALMOST_FULL_THRESHOLD - 2;

  // Unmodified channels
  assign fiu.c0Tx = afu.c0Tx;
  assign fiu.c2Tx = afu.c2Tx;
  assign afu.c0Rx = fiu.c0Rx;
  assign afu.c1Rx = fiu.c1Rx;
  assign afu.c0TxAlmFull = fiu.c0TxAlmFull;

  logic afu_rst_q;

  // AFU reset follows reset, releasing one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) afu_rst_q <= 1'b1;
    else       afu_rst_q <= 1'b0;
  end

  assign afu.reset = afu_rst_q;

  // c1 control FIFO
  t_c1_tx fifo_mem [C1_CTRL_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic   enq, deq, empty, full;
  t_c1_tx head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(C1_CTRL_FIFO_DEPTH));
  assign enq   = afu.c1Tx.valid & ~full;
  assign head  = fifo_mem[rd_ptr_q];
  assign cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);

  assign afu.c1TxAlmFull = reset | fiu.c1TxAlmFull |
                           (cnt_q >= CNT_W'(ALM_LVL));

  // FIFO storage, not reset.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr_q] <= afu.c1Tx;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Build one beat of a flit; non-writes pass through unchanged.
  function automatic t_c1_beat mk_beat(
    input t_c1_tx h,
    input t_write_heap_beat b
  );
    t_c1_beat r;
    r.valid = 1'b1;
    r.wr    = (h.req == C1_WRITE);
    r.last  = (b == h.cl_len);
    r.idx   = t_write_heap_idx'(h.data[IDX_W-1:0]);
    r.beat  = b;
    r.hdr   = h;
    if (r.wr) begin
      r.hdr.sop  = (b == '0);
      r.hdr.addr = beat_addr(h.addr, b);
    end
    return r;
  endfunction

  t_edge_state      state_q, state_d;
  t_write_heap_beat beat_q, beat_d;
  t_c1_tx           cur_q, cur_d;
  t_c1_beat         s1_q, s1_d, s2_q;

  // Beat FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cur_q   <= cur_d;
    end
  end

  // Dequeue in IDLE when allowed; BEAT streams the rest unconditionally.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cur_d   = cur_q;
    deq     = 1'b0;
    s1_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !fiu.c1TxAlmFull) begin
          deq  = 1'b1;
          s1_d = mk_beat(head, 2'd0);
          if (head.req == C1_WRITE && head.cl_len != '0) begin
            state_d = ST_BEAT;
            beat_d  = 2'd1;
            cur_d   = head;
          end
        end
      end
      ST_BEAT: begin
        s1_d = mk_beat(cur_q, beat_q);
        if (beat_q == cur_q.cl_len) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  t_cci_cl heap_rdata;

  cci_mpf_shim_edge_fiu_wr_heap #(
    .N_ENTRIES (N_WRITE_HEAP_ENTRIES)
  ) u_wr_heap (
    .clk_i   (clk),
    .wen_i   (afu_edge.wen),
    .waddr_i (HEAP_AW'({afu_edge.widx[IDX_W-1:0], afu_edge.wclnum})),
    .wdata_i (afu_edge.wdata),
    .raddr_i (HEAP_AW'({s1_q.idx[IDX_W-1:0], s1_q.beat})),
    .rdata_o (heap_rdata)
  );

  t_c1_tx          c1tx_q, c1tx_d;
  logic            free_q, free_d;
  t_write_heap_idx freeidx_q;

  assign free_d = s2_q.valid & s2_q.wr & s2_q.last;

  always_comb begin
    c1tx_d       = s2_q.hdr;
    c1tx_d.valid = s2_q.valid;
    if (s2_q.wr) c1tx_d.data = heap_rdata;
  end

  // Issue -> heap read -> output register; reset drops in-flight beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      c1tx_q    <= '0;
      free_q    <= 1'b0;
      freeidx_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s1_q;
      c1tx_q <= c1tx_d;
      free_q <= free_d;
      if (free_d) freeidx_q <= s2_q.idx;
    end
  end

  assign fiu.c1Tx         = c1tx_q;
  assign afu_edge.free    = free_q;
  assign afu_edge.freeidx = freeidx_q;

`ifdef CCI_MPF_SHIM_EDGE_FIU_HEAP_CHECK_EN
  logic [N_WRITE_HEAP_ENTRIES-1:0] slot_vld_q;
  logic [IDX_W-1:0] head_idx;

  assign head_idx = head.data[IDX_W-1:0];

  // Slot becomes valid when written, invalid when freed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld_q <= '0;
    end else begin
      if (free_q) slot_vld_q[freeidx_q[IDX_W-1:0]] <= 1'b0;
      if (afu_edge.wen) slot_vld_q[afu_edge.widx[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Stop on writes or frees naming an empty slot.
  always_ff @(posedge clk) begin
    if (!reset && deq && head.req == C1_WRITE &&
        !slot_vld_q[head_idx])
      $fatal(1, "edge_fiu: write to invalid heap slot %0d", head_idx);
    if (!reset && free_d && !slot_vld_q[s2_q.idx[IDX_W-1:0]])
      $fatal(1, "edge_fiu: free of invalid heap slot %0d", s2_q.idx);
  end
`else
  // No slot tracking in this build.
`endif

endmodule

// File: tb/tb_cci_mpf_shim_edge_fiu.sv
// Directed bench for cci_mpf_shim_edge_fiu.
// Output flits and free pulses are logged and compared per scenario.
module tb_cci_mpf_shim_edge_fiu;
  import cci_mpf_shim_edge_pkg::*;

  typedef struct {
    int     cyc;
    t_c1_tx f;
  } t_rec;

  localparam int ALM_OCC = 16 - 8 - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  t_rec fq[$];
  int fcyc[$];
  int fidx[$];

  cci_mpf_if fiu_if ();
  cci_mpf_if afu_if ();
  cci_mpf_shim_edge_if edge_if ();

  assign fiu_if.reset = rst;

  cci_mpf_shim_edge_fiu dut (
    .clk      (clk),
    .reset    (rst),
    .fiu      (fiu_if.to_fiu),
    .afu      (afu_if.to_afu),
    .afu_edge (edge_if.edge_fiu)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    if (fiu_if.c1Tx.valid === 1'b1)
      fq.push_back('{cyc: cyc, f: fiu_if.c1Tx});
    if (edge_if.free === 1'b1) begin
      fcyc.push_back(cyc);
      fidx.push_back(int'(edge_if.freeidx));
    end
  end

  task automatic chk(input string tag,
                     input logic [575:0] got,
                     input logic [575:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic t_cci_cl pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic t_rec fq_at(input int i);
    t_rec r;
    r.cyc = -1;
    r.f = '0;
    if (i < fq.size()) r = fq[i];
    return r;
  endfunction

  function automatic int fcyc_at(input int i);
    if (i < fcyc.size()) return fcyc[i];
    return -1;
  endfunction

  function automatic int fidx_at(input int i);
    if (i < fidx.size()) return fidx[i];
    return -1;
  endfunction

  task automatic clr();
    fq.delete();
    fcyc.delete();
    fidx.delete();
  endtask

  task automatic heap_wr(input int idx, input int b,
                         input t_cci_cl d);
    edge_if.wen = 1'b1;
    edge_if.widx = t_write_heap_idx'(idx);
    edge_if.wclnum = t_write_heap_beat'(b);
    edge_if.wdata = d;
    tick();
    edge_if.wen = 1'b0;
  endtask

  task automatic send(input t_c1_req r, input int idx,
                      input t_cci_claddr a, input int len,
                      output int t);
    afu_if.c1Tx.valid = 1'b1;
    afu_if.c1Tx.req = r;
    afu_if.c1Tx.sop = 1'b1;
    afu_if.c1Tx.cl_len = t_write_heap_beat'(len);
    afu_if.c1Tx.addr = a;
    afu_if.c1Tx.data = t_cci_cl'(idx);
    tick();
    t = cyc;
    afu_if.c1Tx.valid = 1'b0;
  endtask

  initial begin
    int t, tb, rel;
    t_rec r;
    t_c0_tx e0;
    t_c2_tx e2;
    t_c0_rx er0;
    t_c1_rx er1;

    afu_if.c0Tx = '0;
    afu_if.c1Tx = '0;
    afu_if.c2Tx = '0;
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    fiu_if.c0Rx = '0;
    fiu_if.c1Rx = '0;
    edge_if.wen = 1'b0;
    edge_if.widx = '0;
    edge_if.wclnum = '0;
    edge_if.wdata = '0;

    // Reset state
    tick(3);
    chk("rst_valid", fiu_if.c1Tx.valid, 0);
    chk("rst_free", edge_if.free, 0);
    chk("rst_freeidx", edge_if.freeidx, 0);
    chk("rst_almfull", afu_if.c1TxAlmFull, 1);
    chk("rst_afu_reset", afu_if.reset, 1);
    rst = 1'b0;
    #1;
    chk("afu_reset_hold", afu_if.reset, 1);
    tick();
    chk("afu_reset_rel", afu_if.reset, 0);
    chk("idle_almfull", afu_if.c1TxAlmFull, 0);

    // Pass-through channels
    e0 = '{valid: 1'b1, addr: 42'h123, mdata: 16'hbeef};
    e2 = '{valid: 1'b1, data: 64'hcafe_f00d};
    er0 = '{valid: 1'b1, mdata: 16'h77, data: pat(8'h3c)};
    er1 = '{valid: 1'b1, mdata: 16'h55};
    afu_if.c0Tx = e0;
    afu_if.c2Tx = e2;
    fiu_if.c0Rx = er0;
    fiu_if.c1Rx = er1;
    fiu_if.c0TxAlmFull = 1'b1;
    #1;
    chk("pt_c0tx", fiu_if.c0Tx, e0);
    chk("pt_c2tx", fiu_if.c2Tx, e2);
    chk("pt_c0rx", afu_if.c0Rx, er0);
    chk("pt_c1rx", afu_if.c1Rx, er1);
    chk("pt_c0alm", afu_if.c0TxAlmFull, 1);
    afu_if.c0Tx = '0;
    afu_if.c2Tx = '0;
    fiu_if.c0Rx = '0;
    fiu_if.c1Rx = '0;
    fiu_if.c0TxAlmFull = 1'b0;
    tick();

    // Single-line write, idx 5
    clr();
    heap_wr(5, 0, pat(8'ha5));
    send(C1_WRITE, 5, 42'h40, 0, t);
    tick(8);
    r = fq_at(0);
    chk("t1_nflit", fq.size(), 1);
    chk("t1_cyc", r.cyc, t + 3);
    chk("t1_sop", r.f.sop, 1);
    chk("t1_addr", r.f.addr, 42'h40);
    chk("t1_data", r.f.data, pat(8'ha5));
    chk("t1_nfree", fcyc.size(), 1);
    chk("t1_freeidx", fidx_at(0), 5);
    chk("t1_freecyc", fcyc_at(0), t + 3);

    // 4-beat write, idx 9, addr 0x100
    clr();
    for (int b = 0; b < 4; b++) heap_wr(9, b, pat(8'(8'h90 + b)));
    send(C1_WRITE, 9, 42'h100, 3, t);
    tick(10);
    chk("t2_nflit", fq.size(), 4);
    for (int b = 0; b < 4; b++) begin
      r = fq_at(b);
      chk($sformatf("t2_cyc%0d", b), r.cyc, t + 3 + b);
      chk($sformatf("t2_addr%0d", b), r.f.addr, 42'h100 + b);
      chk($sformatf("t2_sop%0d", b), r.f.sop, b == 0);
      chk($sformatf("t2_len%0d", b), r.f.cl_len, 3);
      chk($sformatf("t2_data%0d", b), r.f.data, pat(8'(8'h90 + b)));
    end
    chk("t2_nfree", fcyc.size(), 1);
    chk("t2_freeidx", fidx_at(0), 9);
    chk("t2_freecyc", fcyc_at(0), t + 6);

    // Almost-full raised after beat 0
    clr();
    for (int b = 0; b < 4; b++) heap_wr(3, b, pat(8'(8'h30 + b)));
    heap_wr(4, 0, pat(8'h44));
    send(C1_WRITE, 3, 42'h200, 3, t);
    send(C1_WRITE, 4, 42'h280, 0, tb);
    fiu_if.c1TxAlmFull = 1'b1;
    #1;
    chk("t3_afu_alm", afu_if.c1TxAlmFull, 1);
    tick(9);
    chk("t3_nflit_held", fq.size(), 4);
    for (int b = 0; b < 4; b++) begin
      r = fq_at(b);
      chk($sformatf("t3_cyc%0d", b), r.cyc, t + 3 + b);
      chk($sformatf("t3_data%0d", b), r.f.data, pat(8'(8'h30 + b)));
    end
    fiu_if.c1TxAlmFull = 1'b0;
    rel = cyc;
    tick(6);
    r = fq_at(4);
    chk("t3_nflit", fq.size(), 5);
    chk("t3_b_cyc", r.cyc, rel + 3);
    chk("t3_b_data", r.f.data, pat(8'h44));
    chk("t3_nfree", fcyc.size(), 2);
    chk("t3_free0", fidx_at(0), 3);
    chk("t3_free0cyc", fcyc_at(0), t + 6);
    chk("t3_free1", fidx_at(1), 4);

    // Fence between two 2-beat writes
    clr();
    for (int b = 0; b < 2; b++) begin
      heap_wr(1, b, pat(8'(8'h10 + b)));
      heap_wr(2, b, pat(8'(8'h20 + b)));
    end
    send(C1_WRITE, 1, 42'h400, 1, t);
    send(C1_FENCE, 0, 42'h0, 0, tb);
    send(C1_WRITE, 2, 42'h500, 1, tb);
    tick(10);
    chk("t4_nflit", fq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      r = fq_at(i);
      chk($sformatf("t4_cyc%0d", i), r.cyc, t + 3 + i);
      chk($sformatf("t4_req%0d", i), r.f.req,
          (i == 2) ? C1_FENCE : C1_WRITE);
    end
    chk("t4_d0", fq_at(0).f.data, pat(8'h10));
    chk("t4_d1", fq_at(1).f.data, pat(8'h11));
    chk("t4_d3", fq_at(3).f.data, pat(8'h20));
    chk("t4_d4", fq_at(4).f.data, pat(8'h21));
    chk("t4_a4", fq_at(4).f.addr, 42'h501);
    chk("t4_nfree", fcyc.size(), 2);
    chk("t4_free0", fidx_at(0), 1);
    chk("t4_free0cyc", fcyc_at(0), t + 4);
    chk("t4_free1", fidx_at(1), 2);
    chk("t4_free1cyc", fcyc_at(1), t + 7);

    // Fill FIFO under almost-full, then drain
    clr();
    for (int k = 0; k < 16; k++) heap_wr(16 + k, 0, pat(8'(8'h60 + k)));
    fiu_if.c1TxAlmFull = 1'b1;
    for (int k = 0; k < 16; k++)
      send(C1_WRITE, 16 + k, 42'h1000 + k, 0, tb);
    tick(2);
    fiu_if.c1TxAlmFull = 1'b0;
    rel = cyc;
    #1;
    chk("t5_alm_occ16", afu_if.c1TxAlmFull, 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t5_alm_occ%0d", 16 - k), afu_if.c1TxAlmFull,
          (16 - k) >= ALM_OCC);
    end
    tick(4);
    chk("t5_nflit", fq.size(), 16);
    chk("t5_nfree", fcyc.size(), 16);
    for (int k = 0; k < 16; k++) begin
      r = fq_at(k);
      chk($sformatf("t5_cyc%0d", k), r.cyc, rel + 3 + k);
      chk($sformatf("t5_data%0d", k), r.f.data, pat(8'(8'h60 + k)));
      chk($sformatf("t5_free%0d", k), fidx_at(k), 16 + k);
    end

    // Reset during beat 2 of a 4-beat write
    clr();
    for (int b = 0; b < 4; b++) heap_wr(7, b, pat(8'(8'h70 + b)));
    send(C1_WRITE, 7, 42'h300, 3, t);
    tick(5);
    chk("t6_b2_valid", fiu_if.c1Tx.valid, 1);
    chk("t6_b2_addr", fiu_if.c1Tx.addr, 42'h302);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", fiu_if.c1Tx.valid, 0);
    chk("t6_rst_free", edge_if.free, 0);
    chk("t6_rst_alm", afu_if.c1TxAlmFull, 1);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("t6_nflit", fq.size(), 3);
    chk("t6_nfree", fcyc.size(), 0);
    chk("t6_afu_reset", afu_if.reset, 0);
    send(C1_WRITE, 5, 42'h40, 0, t);
    tick(8);
    r = fq_at(3);
    chk("t6_re_nflit", fq.size(), 4);
    chk("t6_re_cyc", r.cyc, t + 3);
    chk("t6_re_data", r.f.data, pat(8'ha5));
    chk("t6_re_nfree", fcyc.size(), 1);
    chk("t6_re_freeidx", fidx_at(0), 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
